// File: rtl/eth_pkg.sv
// Shared Ethernet constants, the stored-beat layout, and a saturating-increment helper.
package eth_pkg;

    localparam int ETH_MAX_FRAME = 1518;
    localparam int ETH_MIN_FRAME = 60;

    // One byte as held in the frame buffer: end-of-frame marker above the data byte.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } eth_beat_t;

    // Counters of up to 32 bits are passed through this helper widened to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
// The read register is reset so that the downstream stage comes up with known data.
module eth_sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Storage array write; no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; only updates when a read is requested so the output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward byte FIFO in front of the MAC transmit path. A frame becomes
// visible downstream only after its last byte is in and it was not flagged bad or
// overflowed; rejected frames are rewound away by restoring wr_ptr to wr_commit.
module eth_tx_frame_fifo
    import eth_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   frames_stored,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  good_count
);

    localparam logic [ADDR_W:0]  DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] wr_commit;
    logic [ADDR_W:0] rd_ptr;
    logic            drop_flag;
    logic            accept;
    logic            full;
    logic            discard;
    logic            commit;
    logic            wr_en;
    logic            load;
    logic            rd_handshake;
    eth_beat_t       wr_beat;
    eth_beat_t       rd_beat;

    assign accept       = s_axis_tvalid & s_axis_tready;
    assign full         = (wr_ptr - rd_ptr) == DEPTH_P;
    assign discard      = accept & s_axis_tlast & (drop_flag | full | s_axis_tuser);
    assign commit       = accept & s_axis_tlast & ~discard;
    assign wr_en        = accept & ~drop_flag & ~full & ~(s_axis_tlast & s_axis_tuser);
    assign rd_handshake = m_axis_tvalid & m_axis_tready;
    assign load         = (rd_ptr != wr_commit) & (~m_axis_tvalid | m_axis_tready);
    assign wr_beat      = '{last: s_axis_tlast, data: s_axis_tdata};
    assign m_axis_tlast = rd_beat.last;
    assign m_axis_tdata = rd_beat.data;

    eth_sdp_ram #(
        .WIDTH  ($bits(eth_beat_t)),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_beat),
        .rd_en   (load),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_beat)
    );

    // Write side: advance on stored bytes, publish on good tlast, rewind on discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axis_tready <= 1'b0;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            drop_flag     <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            if (discard) begin
                wr_ptr    <= wr_commit;
                drop_flag <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (commit) begin
                    wr_commit <= wr_ptr + 1'b1;
                end
                if (accept & full & ~s_axis_tlast) begin
                    drop_flag <= 1'b1;
                end
            end
        end
    end

    // Read side: the RAM read register is the output stage, refilled whenever it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            rd_ptr        <= rd_ptr + 1'b1;
            m_axis_tvalid <= 1'b1;
        end else if (rd_handshake) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Committed-but-unread frame count; a commit and a final-byte read together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_stored <= '0;
        end else begin
            case ({commit, rd_handshake & m_axis_tlast})
                2'b10:   frames_stored <= frames_stored + 1'b1;
                2'b01:   frames_stored <= frames_stored - 1'b1;
                default: frames_stored <= frames_stored;
            endcase
        end
    end

    // Statistics: one-cycle drop pulse and saturating good/drop frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
            good_count <= '0;
        end else begin
            drop_pulse <= discard;
            if (discard) begin
                drop_count <= CNT_W'(sat_inc(32'(drop_count), 32'(CNT_MAX)));
            end
            if (commit) begin
                good_count <= CNT_W'(sat_inc(32'(good_count), 32'(CNT_MAX)));
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Directed bench for the store-and-forward TX FIFO with a small (64-byte) buffer.
// Good frames push their bytes into a scoreboard as they are driven; a monitor pops
// and compares on each output handshake and checks AXI-S hold behaviour on stalls.
module tb_eth_tx_frame_fifo;

    localparam int ADDR_W = 6;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic [7:0]        s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tuser;
    logic              s_axis_tready;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [ADDR_W:0]   frames_stored;
    logic              drop_pulse;
    logic [CNT_W-1:0]  drop_count;
    logic [CNT_W-1:0]  good_count;

    logic [8:0] exp_q [$];
    logic [8:0] exp_beat;
    logic [8:0] prev_beat;
    logic       prev_stall;
    int         checks;
    int         errors;
    int         mon_checks;
    int         mon_errors;

    eth_tx_frame_fifo #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frames_stored (frames_stored),
        .drop_pulse    (drop_pulse),
        .drop_count    (drop_count),
        .good_count    (good_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: scoreboard compare on handshakes, hold check after stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                mon_checks++;
                assert ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} === {1'b1, prev_beat})
                else begin
                    mon_errors++;
                    $error("[TB] FAIL hold observed=%h expected=%h",
                           {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                mon_checks++;
                if (exp_q.size() == 0) begin
                    mon_errors++;
                    $error("[TB] FAIL unexpected_beat observed=%h expected=none",
                           {m_axis_tlast, m_axis_tdata});
                end else begin
                    exp_beat = exp_q.pop_front();
                    assert ({m_axis_tlast, m_axis_tdata} === exp_beat)
                    else begin
                        mon_errors++;
                        $error("[TB] FAIL out_beat observed=%h expected=%h",
                               {m_axis_tlast, m_axis_tdata}, exp_beat);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one input beat and let one rising edge take it.
    task automatic apply_stimulus(input logic [7:0] data, input logic last, input logic user);
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input logic bad, input logic expect_out);
        for (int i = 0; i < len; i++) begin
            if (expect_out) begin
                exp_q.push_back({(i == len - 1), 8'(base + i)});
            end
            apply_stimulus(8'(base + i), (i == len - 1), bad && (i == len - 1));
        end
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(tag, exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check_output({tag, "_idle"}, m_axis_tvalid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_s_ready"}, s_axis_tready, 0);
        check_output({tag, "_m_valid"}, m_axis_tvalid, 0);
        check_output({tag, "_m_data"}, m_axis_tdata, 0);
        check_output({tag, "_m_last"}, m_axis_tlast, 0);
        check_output({tag, "_stored"}, frames_stored, 0);
        check_output({tag, "_pulse"}, drop_pulse, 0);
        check_output({tag, "_drops"}, drop_count, 0);
        check_output({tag, "_goods"}, good_count, 0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        mon_checks    = 0;
        mon_errors    = 0;
        prev_stall    = 1'b0;
        rst_n         = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state, then tready rises on the first clock after release.
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("rst_ready_low", s_axis_tready, 0);
        @(posedge clk);
        #1;
        check_output("rst_ready_high", s_axis_tready, 1);

        // 1: good 64-byte frame, output starts two edges after the tlast beat.
        $display("[TB] step 1: good 64-byte frame");
        send_frame(64, 8'h00, 1'b0, 1'b1);
        check_output("t1_valid_early", m_axis_tvalid, 0);
        check_output("t1_stored", frames_stored, 1);
        check_output("t1_good", good_count, 1);
        @(posedge clk);
        #1;
        check_output("t1_valid_first", m_axis_tvalid, 1);
        check_output("t1_data_first", {m_axis_tlast, m_axis_tdata}, 9'h000);
        drain("t1_drain", 200);
        check_output("t1_stored_end", frames_stored, 0);

        // 2: same frame flagged bad on tlast is discarded whole.
        $display("[TB] step 2: bad frame via tuser");
        send_frame(64, 8'h00, 1'b1, 1'b0);
        check_output("t2_pulse", drop_pulse, 1);
        check_output("t2_drops", drop_count, 1);
        check_output("t2_stored", frames_stored, 0);
        @(posedge clk);
        #1;
        check_output("t2_pulse_once", drop_pulse, 0);
        drain("t2_drain", 10);

        // 3: stalled sink, second 40-byte frame overflows and is dropped.
        $display("[TB] step 3: overflow of second frame");
        m_axis_tready = 1'b0;
        send_frame(40, 8'h40, 1'b0, 1'b1);
        send_frame(40, 8'h80, 1'b0, 1'b0);
        check_output("t3_drops", drop_count, 2);
        check_output("t3_good", good_count, 2);
        check_output("t3_stored", frames_stored, 1);
        m_axis_tready = 1'b1;
        drain("t3_drain", 200);

        // 4: oversize frame dropped, following short frame intact.
        $display("[TB] step 4: oversize frame then short frame");
        send_frame(70, 8'hA0, 1'b0, 1'b0);
        check_output("t4_drops", drop_count, 3);
        send_frame(10, 8'h10, 1'b0, 1'b1);
        drain("t4_drain", 100);
        check_output("t4_good", good_count, 3);

        // 5: three single-byte frames read out with a toggling ready.
        $display("[TB] step 5: single-byte frames, toggling ready");
        m_axis_tready = 1'b0;
        send_frame(1, 8'hC1, 1'b0, 1'b1);
        send_frame(1, 8'hC2, 1'b0, 1'b1);
        send_frame(1, 8'hC3, 1'b0, 1'b1);
        check_output("t5_stored3", frames_stored, 3);
        for (int i = 0; i < 12; i++) begin
            m_axis_tready = ~m_axis_tready;
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        drain("t5_drain", 20);
        check_output("t5_stored0", frames_stored, 0);

        // 6: reset in the middle of a frame; next frame passes with nothing stale.
        $display("[TB] step 6: reset mid-frame");
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(8'(8'h60 + i), 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("t6_ready", s_axis_tready, 1);
        send_frame(60, 8'h20, 1'b0, 1'b1);
        drain("t6_drain", 150);
        check_output("t6_good", good_count, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks + mon_checks, errors + mon_errors);
        $finish;
    end

endmodule
